cache_trace_driver: RTL and testbench

// - Request-side initiator for cache_top: buffers trace entries (addr, op, level) from a host/testbench push port.
// - Drives cache_addr/cache_op/cache_lvl one entry at a time, holding each stable for a fixed window.
// - cache_top detects a new request only on an address change. This block therefore owns duplicate handling and pacing.

---
 rtl/cache_trace_pkg.sv | 30 +++
 rtl/trace_fifo.sv | 49 ++++
 rtl/cache_trace_driver.sv | 159 +++++++++++++++
 tb/tb_cache_trace_driver.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_trace_pkg.sv
// Shared types for the cache trace driver: trace entries, FSM states
// and the op codes / spacer address it understands.
package cache_trace_pkg;

    localparam int ADDR_W = 48;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;

    localparam logic [ADDR_W-1:0] SPACER_ADDR = {ADDR_W{1'b1}};

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        op;
        logic              lvl;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRIVE,
        SPACER
    } drv_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries with extra-bit wrap pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module trace_fifo
    import cache_trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t wdata,
    output trace_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t   mem_q [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cache_trace_driver.sv
// Paces buffered trace entries onto the cache request port, one per hold window.
// Optional macro DUP_SPACER_EN: duplicates get a spacer address instead of being dropped.
module cache_trace_driver
    import cache_trace_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_op,
    input  logic              in_lvl,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [7:0]        cache_op,
    output logic              cache_lvl,
    output logic              busy,
    output logic [15:0]       issued_count,
    output logic [15:0]       dup_count,
    output logic [15:0]       bad_op_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    drv_state_t        state_q, state_d;
    trace_entry_t      entry_q, entry_d;
    trace_entry_t      out_q, out_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [15:0]       issued_q, issued_d;
    logic [15:0]       dup_q, dup_d;
    logic [15:0]       bad_q, bad_d;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    trace_entry_t fifo_wdata;
    trace_entry_t fifo_rdata;

    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
    assign in_ready   = !fifo_full || fifo_pop;
    assign fifo_push  = in_valid && in_ready;
    assign fifo_wdata = '{addr: in_addr, op: in_op, lvl: in_lvl};

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cache_addr   = out_q.addr;
    assign cache_op     = out_q.op;
    assign cache_lvl    = out_q.lvl;
    assign busy         = !fifo_empty || (state_q != IDLE);
    assign issued_count = issued_q;
    assign dup_count    = dup_q;
    assign bad_op_count = bad_q;

    // State, held entry, outputs and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            out_q    <= '0;
            last_q   <= '0;
            hold_q   <= '0;
            issued_q <= '0;
            dup_q    <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            out_q    <= out_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            issued_q <= issued_d;
            dup_q    <= dup_d;
            bad_q    <= bad_d;
        end
    end

    // Next state: classify each popped entry, then hold the cache port.
    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        out_d    = out_q;
        last_d   = last_q;
        hold_d   = hold_q;
        issued_d = issued_q;
        dup_d    = dup_q;
        bad_d    = bad_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    entry_d = fifo_rdata;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (entry_q.op != OP_W && entry_q.op != OP_R) begin
                    bad_d   = sat_inc(bad_q);
                    state_d = IDLE;
                end else if (entry_q.addr == last_q) begin
                    dup_d = sat_inc(dup_q);
`ifdef DUP_SPACER_EN
                    out_d.addr = SPACER_ADDR;
                    out_d.op   = entry_q.op;
                    out_d.lvl  = entry_q.lvl;
                    hold_d     = HOLD_LAST;
                    state_d    = SPACER;
`else
                    state_d = IDLE;
`endif
                end else begin
                    out_d    = entry_q;
                    last_d   = entry_q.addr;
                    issued_d = sat_inc(issued_q);
                    hold_d   = HOLD_LAST;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
`ifdef DUP_SPACER_EN
            SPACER: begin
                if (hold_q == '0) begin
                    out_d    = entry_q;
                    last_d   = entry_q.addr;
                    issued_d = sat_inc(issued_q);
                    hold_d   = HOLD_LAST;
                    state_d  = DRIVE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_trace_driver.sv
// Self-checking bench for cache_trace_driver against a queue-based trace model.
module tb_cache_trace_driver;
    import cache_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int HOLD  = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [7:0]        in_op;
    logic              in_lvl;
    logic [ADDR_W-1:0] cache_addr;
    logic [7:0]        cache_op;
    logic              cache_lvl;
    logic              busy;
    logic [15:0]       issued_count;
    logic [15:0]       dup_count;
    logic [15:0]       bad_op_count;

    cache_trace_driver #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_op        (in_op),
        .in_lvl       (in_lvl),
        .cache_addr   (cache_addr),
        .cache_op     (cache_op),
        .cache_lvl    (cache_lvl),
        .busy         (busy),
        .issued_count (issued_count),
        .dup_count    (dup_count),
        .bad_op_count (bad_op_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed address changes on the cache port, sampled 1 unit after each edge.
    logic [ADDR_W-1:0] obs_addr[$];
    logic [7:0]        obs_op[$];
    logic              obs_lvl[$];
    int                obs_t[$];
    logic [ADDR_W-1:0] mon_prev = '0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (cache_addr !== mon_prev) begin
            obs_addr.push_back(cache_addr);
            obs_op.push_back(cache_op);
            obs_lvl.push_back(cache_lvl);
            obs_t.push_back(cyc);
        end
        mon_prev = cache_addr;
    end

    // Reference model: entries are consumed in order by simple rules.
    logic [ADDR_W-1:0] m_last;
    int                m_issued, m_dup, m_bad;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [7:0]        exp_op[$];
    logic              exp_lvl[$];
    bit                exp_sp[$];

    task automatic model_clear();
        m_last = '0;
        m_issued = 0;
        m_dup = 0;
        m_bad = 0;
        exp_addr.delete();
        exp_op.delete();
        exp_lvl.delete();
        exp_sp.delete();
    endtask

    task automatic model_push(input logic [ADDR_W-1:0] a, input logic [7:0] o,
                              input logic l);
        if (o != 8'h57 && o != 8'h52) begin
            m_bad++;
        end else if (a == m_last) begin
            m_dup++;
`ifdef DUP_SPACER_EN
            exp_addr.push_back({ADDR_W{1'b1}});
            exp_op.push_back(o);
            exp_lvl.push_back(l);
            exp_sp.push_back(1'b1);
            exp_addr.push_back(a);
            exp_op.push_back(o);
            exp_lvl.push_back(l);
            exp_sp.push_back(1'b0);
            m_issued++;
`endif
        end else begin
            exp_addr.push_back(a);
            exp_op.push_back(o);
            exp_lvl.push_back(l);
            exp_sp.push_back(1'b0);
            m_last = a;
            m_issued++;
        end
    endtask

    task automatic obs_clear();
        obs_addr.delete();
        obs_op.delete();
        obs_lvl.delete();
        obs_t.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = '0;
        in_op    = '0;
        in_lvl   = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        obs_clear();
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [7:0] o,
                        input logic l, output bit stalled);
        int n;
        n = 0;
        stalled = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        in_op    = o;
        in_lvl   = l;
        while (!in_ready && n < 300) begin
            stalled = 1'b1;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout addr=%h in_ready stuck at 0, required 1", a);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(a, o, l);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout busy=1 after %0d cycles, required 0", tag, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_op = '0;
        in_lvl = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags in_ready=%b busy=%b, required 1/0", in_ready, busy);
        end
        checks++;
        if (cache_addr !== '0 || cache_op !== 8'h00 || cache_lvl !== 1'b0) begin
            errors++;
            $display("FAIL reset_cache got %h/%h/%b, required 0/0/0",
                     cache_addr, cache_op, cache_lvl);
        end
        checks++;
        if (issued_count !== 16'd0 || dup_count !== 16'd0 || bad_op_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d/%0d, required 0/0/0",
                     issued_count, dup_count, bad_op_count);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        obs_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cache_addr !== '0 || issued_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_release busy=%b addr=%h issued=%0d, required 0/0/0",
                     busy, cache_addr, issued_count);
        end
    endtask

    task automatic test_basic();
        bit st;
        do_reset();
        push(48'h1000, 8'h57, 1'b1, st);
        push(48'h2040, 8'h52, 1'b0, st);
        drop_valid();
        wait_idle("basic");
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL basic_len got %0d, required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_op[i] !== exp_op[i] ||
                obs_lvl[i] !== exp_lvl[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d] got %h/%h/%b, required %h/%h/%b", i,
                         obs_addr[i], obs_op[i], obs_lvl[i], exp_addr[i], exp_op[i], exp_lvl[i]);
            end
        end
        checks++;
        if (obs_t.size() == 2 && obs_t[1] - obs_t[0] != HOLD + 2) begin
            errors++;
            $display("FAIL basic_spacing got %0d cycles, required %0d",
                     obs_t[1] - obs_t[0], HOLD + 2);
        end
        checks++;
        if (issued_count !== 16'd2 || cache_op !== 8'h52 || cache_addr !== 48'h2040) begin
            errors++;
            $display("FAIL basic_final issued=%0d op=%h addr=%h, required 2/52/2040",
                     issued_count, cache_op, cache_addr);
        end
    endtask

    task automatic test_back_to_back();
        bit st;
        int first_stall;
        first_stall = -1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(48'h1000 + 48'(i) * 48'h40, (i % 2 == 0) ? 8'h57 : 8'h52, i[0], st);
            if (st && first_stall < 0) first_stall = i;
        end
        drop_valid();
        wait_idle("b2b");
        checks++;
        if (first_stall < DEPTH || first_stall > DEPTH + 4) begin
            errors++;
            $display("FAIL b2b_stall accepted %0d before in_ready low, required %0d..%0d",
                     first_stall, DEPTH, DEPTH + 4);
        end
        checks++;
        if (obs_addr.size() != 20 || exp_addr.size() != 20) begin
            errors++;
            $display("FAIL b2b_len got %0d, required 20", obs_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_op[i] !== exp_op[i]) begin
                errors++;
                $display("FAIL b2b_seq[%0d] got %h/%h, required %h/%h", i,
                         obs_addr[i], obs_op[i], exp_addr[i], exp_op[i]);
            end
        end
        checks++;
        if (issued_count !== 16'd20) begin
            errors++;
            $display("FAIL b2b_issued got %0d, required 20", issued_count);
        end
    endtask

    task automatic test_dup();
        bit st;
        do_reset();
        push(48'h40, 8'h52, 1'b0, st);
        push(48'h40, 8'h52, 1'b0, st);
        drop_valid();
        wait_idle("dup");
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL dup_len got %0d, required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL dup_seq[%0d] got %h, required %h", i, obs_addr[i], exp_addr[i]);
            end
        end
        checks++;
        if (dup_count !== 16'd1 || issued_count !== 16'(m_issued)) begin
            errors++;
            $display("FAIL dup_counts dup=%0d issued=%0d, required 1/%0d",
                     dup_count, issued_count, m_issued);
        end
    endtask

    task automatic test_bad_op();
        bit st;
        do_reset();
        push(48'h70, 8'h58, 1'b1, st);
        push(48'h80, 8'h52, 1'b1, st);
        drop_valid();
        wait_idle("badop");
        checks++;
        if (obs_addr.size() != 1 || (obs_addr.size() == 1 && obs_addr[0] !== 48'h80)) begin
            errors++;
            $display("FAIL badop_seq got %0d changes, last addr=%h, required 1 change to 80",
                     obs_addr.size(), cache_addr);
        end
        checks++;
        if (bad_op_count !== 16'd1 || issued_count !== 16'd1 || dup_count !== 16'd0) begin
            errors++;
            $display("FAIL badop_counts bad=%0d issued=%0d dup=%0d, required 1/1/0",
                     bad_op_count, issued_count, dup_count);
        end
    endtask

    task automatic test_addr0();
        bit st;
        do_reset();
        push(48'h0, 8'h57, 1'b1, st);
        drop_valid();
        wait_idle("addr0");
        checks++;
        if (dup_count !== 16'd1 || cache_addr !== '0) begin
            errors++;
            $display("FAIL addr0 dup=%0d addr=%h, required 1/0", dup_count, cache_addr);
        end
        checks++;
        if (obs_addr.size() != exp_addr.size() || issued_count !== 16'(m_issued)) begin
            errors++;
            $display("FAIL addr0_trace changes=%0d issued=%0d, required %0d/%0d",
                     obs_addr.size(), issued_count, exp_addr.size(), m_issued);
        end
    endtask

    task automatic test_reset_mid_drive();
        bit st;
        int n;
        do_reset();
        push(48'h100, 8'h52, 1'b1, st);
        push(48'h200, 8'h57, 1'b1, st);
        drop_valid();
        n = 0;
        while (cache_addr !== 48'h100 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (cache_addr !== 48'h100) begin
            errors++;
            $display("FAIL rstmid_start addr=%h, required 100", cache_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (cache_addr !== '0 || cache_op !== 8'h00 || cache_lvl !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs addr=%h op=%h lvl=%b busy=%b rdy=%b, required 0/0/0/0/1",
                     cache_addr, cache_op, cache_lvl, busy, in_ready);
        end
        checks++;
        if (issued_count !== 16'd0 || dup_count !== 16'd0 || bad_op_count !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_counters got %0d/%0d/%0d, required 0/0/0",
                     issued_count, dup_count, bad_op_count);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        obs_clear();
        push(48'h300, 8'h52, 1'b0, st);
        drop_valid();
        wait_idle("rstmid");
        checks++;
        if (obs_addr.size() != 1 || (obs_addr.size() == 1 && obs_addr[0] !== 48'h300) ||
            issued_count !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_after changes=%0d addr=%h issued=%0d, required 1/300/1",
                     obs_addr.size(), cache_addr, issued_count);
        end
    endtask

    task automatic test_random();
        bit st;
        logic [7:0] o;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(7))
                0: o = 8'($urandom);
                1, 2, 3: o = 8'h57;
                default: o = 8'h52;
            endcase
            push(48'h40 * 48'($urandom_range(5)), o, 1'($urandom), st);
            if ($urandom_range(3) == 0) begin
                drop_valid();
                repeat ($urandom_range(12)) @(negedge clk);
            end
        end
        drop_valid();
        wait_idle("rand");
        checks++;
        if (obs_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL rand_len got %0d, required %0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] ||
                (!exp_sp[i] && (obs_op[i] !== exp_op[i] || obs_lvl[i] !== exp_lvl[i]))) begin
                errors++;
                $display("FAIL rand_seq[%0d] got %h/%h/%b, required %h/%h/%b", i,
                         obs_addr[i], obs_op[i], obs_lvl[i], exp_addr[i], exp_op[i], exp_lvl[i]);
            end
            if (i > 0) begin
                checks++;
                if (exp_sp[i-1] ? (obs_t[i] - obs_t[i-1] != HOLD)
                                : (obs_t[i] - obs_t[i-1] < HOLD + 2)) begin
                    errors++;
                    $display("FAIL rand_gap[%0d] got %0d cycles, required %s%0d", i,
                             obs_t[i] - obs_t[i-1], exp_sp[i-1] ? "" : ">=",
                             exp_sp[i-1] ? HOLD : HOLD + 2);
                end
            end
        end
        checks++;
        if (issued_count !== 16'(m_issued) || dup_count !== 16'(m_dup) ||
            bad_op_count !== 16'(m_bad)) begin
            errors++;
            $display("FAIL rand_counts got %0d/%0d/%0d, required %0d/%0d/%0d",
                     issued_count, dup_count, bad_op_count, m_issued, m_dup, m_bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_addr = '0;
        in_op = '0;
        in_lvl = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_back_to_back();
        test_dup();
        test_bad_op();
        test_addr0();
        test_reset_mid_drive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
